// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N digit counter.
// Provides the digit width function and the count direction type.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Bits needed to hold one digit 0..radix-1, never less than 1.
    function automatic int digit_w(input int radix);
        if (radix <= 2)
            return 1;
        return $clog2(radix);
    endfunction

endpackage

// File: rtl/mod_n_digit_counter_digit.sv
// mod_digit: one modulo-RADIX digit cell with wrap on step and load clamp.
// Ports: clk, rst_n, step, up, load, ld_val -> q, at_max, at_min.
module mod_digit #(
    parameter int RADIX = 10,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          up,
    input  logic          load,
    input  logic [DW-1:0] ld_val,
    output logic [DW-1:0] q,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW-1:0] MAXV = DW'(RADIX - 1);
    localparam logic [DW:0]   LIM  = (DW+1)'(RADIX);

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_ld;
    logic [DW-1:0] w_nxt;

    assign at_max = (r_q == MAXV);
    assign at_min = (r_q == '0);
    assign q      = r_q;

    // Out-of-range load slices are cleared so q stays below RADIX.
    assign w_ld = ({1'b0, ld_val} >= LIM) ? '0 : ld_val;

    always_comb begin
        w_nxt = r_q;
        if (up)
            w_nxt = at_max ? '0 : r_q + DW'(1);
        else
            w_nxt = at_min ? MAXV : r_q - DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (load)
            r_q <= w_ld;
        else if (step)
            r_q <= w_nxt;
    end

endmodule

// File: rtl/mod_n_digit_counter.sv
// Multi-digit modulo-RADIX up/down counter with load and terminal count.
// Ports: clk, rst_n, en, up, load, load_val -> count, tc. Option: SAT_MODE_EN.
module mod_n_digit_counter
    import counter_pkg::*;
#(
    parameter int RADIX  = 10,
    parameter int DIGITS = 2,
    localparam int DW    = digit_w(RADIX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 up,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc
);

    dir_t              w_dir;
    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_bound;
    logic [DIGITS-1:0] w_step;
    logic [DIGITS:0]   w_lo;
    logic              w_edge;
    logic              w_hold;
    logic              r_tc;

    assign w_dir = up ? DIR_UP : DIR_DOWN;

    // w_lo[k]: every digit below k sits at the boundary for this direction.
    always_comb begin
        w_lo    = '0;
        w_lo[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            w_lo[k+1] = w_lo[k] & w_bound[k];
    end

    // Whole value is at all-max (up) or all-0 (down) while enabled.
    assign w_edge = en & w_lo[DIGITS];

`ifdef SAT_MODE_EN
    assign w_hold = w_edge;
`else
    assign w_hold = 1'b0;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign w_bound[k] = (w_dir == DIR_UP) ? w_at_max[k]
                                              : w_at_min[k];
        assign w_step[k]  = en & ~w_hold & w_lo[k];

        mod_digit #(
            .RADIX (RADIX),
            .DW    (DW)
        ) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (w_step[k]),
            .up     (up),
            .load   (load),
            .ld_val (load_val[k*DW +: DW]),
            .q      (count[k*DW +: DW]),
            .at_max (w_at_max[k]),
            .at_min (w_at_min[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tc <= 1'b0;
        else
            r_tc <= ~load & w_edge;
    end

    assign tc = r_tc;

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Self-checking bench for mod_n_digit_counter against an integer model.
// Covers reset, wrap, load priority, direction change and random traffic.
module tb_mod_n_digit_counter;
    import counter_pkg::*;

    localparam int RADIX  = 10;
    localparam int DIGITS = 2;
    localparam int DW     = digit_w(RADIX);
    localparam int W      = DIGITS * DW;
    localparam int MAXN   = RADIX ** DIGITS - 1;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;

    int n_checks;
    int n_fail;
    int m_val;
    logic m_tc;

    mod_n_digit_counter #(
        .RADIX  (RADIX),
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bits(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*DW +: DW] = DW'(t % RADIX);
            t = t / RADIX;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [W-1:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = int'(lv[k*DW +: DW]);
            if (d >= RADIX)
                d = 0;
            v = v + d * p;
            p = p * RADIX;
        end
        return v;
    endfunction

    task automatic drive(input logic l, input logic [W-1:0] lv,
                         input logic e, input logic u);
        load     = l;
        load_val = lv;
        en       = e;
        up       = u;
        @(posedge clk);
        #1;
        if (l) begin
            m_val = from_load(lv);
            m_tc  = 1'b0;
        end else if (e && u) begin
            if (m_val == MAXN) begin
                m_tc = 1'b1;
`ifndef SAT_MODE_EN
                m_val = 0;
`endif
            end else begin
                m_val = m_val + 1;
                m_tc  = 1'b0;
            end
        end else if (e) begin
            if (m_val == 0) begin
                m_tc = 1'b1;
`ifndef SAT_MODE_EN
                m_val = MAXN;
`endif
            end else begin
                m_val = m_val - 1;
                m_tc  = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        up = 1'b1;
        load = 1'b0;
        load_val = '0;
        m_val = 0;
        m_tc = 1'b0;
        #3;
        n_checks++;
        if (count !== '0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: count=%h tc=%b expected 00/0", count, tc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (count !== '0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: count=%h tc=%b expected 00/0", count, tc);
        end
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (count !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: count=%h expected 00", count);
        end
    endtask

    task automatic test_wrap_up();
        int ev[3];
        logic et[3];
`ifdef SAT_MODE_EN
        ev = '{99, 99, 99};
        et = '{1'b0, 1'b1, 1'b1};
`else
        ev = '{99, 0, 1};
        et = '{1'b0, 1'b1, 1'b0};
`endif
        drive(1'b1, to_bits(98), 1'b0, 1'b0);
        n_checks++;
        if (count !== to_bits(98) || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL up_load: count=%h tc=%b expected 98/0", count, tc);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            n_checks++;
            if (count !== to_bits(ev[i]) || tc !== et[i]) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: count=%h tc=%b expected %h/%b",
                         i, count, tc, to_bits(ev[i]), et[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        int ev[3];
        logic et[3];
`ifdef SAT_MODE_EN
        ev = '{0, 0, 0};
        et = '{1'b0, 1'b1, 1'b1};
`else
        ev = '{0, 99, 98};
        et = '{1'b0, 1'b1, 1'b0};
`endif
        drive(1'b1, to_bits(1), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (count !== to_bits(ev[i]) || tc !== et[i]) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: count=%h tc=%b expected %h/%b",
                         i, count, tc, to_bits(ev[i]), et[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        logic [W-1:0] lv;
        drive(1'b1, to_bits(99), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        lv = 8'h5C;
        drive(1'b1, lv, 1'b1, 1'b1);
        n_checks++;
        if (count !== 8'h50 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_prio: count=%h tc=%b expected 50/0", count, tc);
        end
    endtask

    task automatic test_dir_toggle();
        int ev[3];
        logic dv[3];
        ev = '{18, 19, 18};
        dv = '{1'b0, 1'b1, 1'b0};
        drive(1'b1, to_bits(19), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, dv[i]);
            n_checks++;
            if (count !== to_bits(ev[i]) || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_toggle[%0d]: count=%h tc=%b expected %h/0",
                         i, count, tc, to_bits(ev[i]));
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, to_bits(36), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (count !== to_bits(37)) begin
            n_fail++;
            $display("FAIL pre_reset: count=%h expected 37", count);
        end
        #1;
        rst_n = 1'b0;
        m_val = 0;
        m_tc = 1'b0;
        #1;
        n_checks++;
        if (count !== '0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: count=%h tc=%b expected 00/0", count, tc);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (count !== to_bits(1) || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: count=%h tc=%b expected 01/0", count, tc);
        end
    endtask

`ifdef SAT_MODE_EN
    task automatic test_sat();
        drive(1'b1, to_bits(99), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            n_checks++;
            if (count !== to_bits(99) || tc !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_hold[%0d]: count=%h tc=%b expected 99/1",
                         i, count, tc);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (count !== to_bits(98) || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_down: count=%h tc=%b expected 98/0", count, tc);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] lv;
        logic l;
        logic e;
        logic u;
        int sel;
        for (int i = 0; i < 400; i++) begin
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 3);
            if (sel == 0)
                lv = to_bits(MAXN);
            else if (sel == 1)
                lv = '0;
            else
                lv = W'($urandom);
            drive(l, lv, e, u);
            n_checks++;
            if (count !== to_bits(m_val) || tc !== m_tc) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%h tc=%b expected %h/%b",
                         i, count, tc, to_bits(m_val), m_tc);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_dir_toggle();
        test_async_reset();
`ifdef SAT_MODE_EN
        test_sat();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
